// File: rtl/fmap_frame_buffer.sv
// fmap_frame_buffer
//   Captures one WIDTH*WIDTH feature-map frame (CHANNELS x DATA_WIDTH bits per
//   pixel beat) from the upstream layer and replays it in raster order to the
//   downstream layer under valid/ready flow control.
//
//   Optional build macro: FMAP_PINGPONG_EN
//     undefined : one bank; the input is closed (in_ready=0) while a frame drains.
//     defined   : two banks; a frame fills while the other drains. The input
//                 closes only when both banks hold frames not yet replayed.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   i_data     input pixel beat           valid_in  beat valid
//   in_ready   buffer accepts a beat (registered)
//   o_data     replayed pixel beat        valid_out o_data valid
//   o_ready    downstream accepts o_data
//   frame_done one-cycle pulse after the last beat of a frame is accepted
//   overflow   sticky: a beat arrived while in_ready=0
//   wr_count   beats written into the frame currently filling
module fmap_frame_buffer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int CHANNELS   = 32,
  parameter  int WIDTH      = 14,
  localparam int DIM        = WIDTH * WIDTH,
  localparam int AW         = $clog2(DIM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH*CHANNELS-1:0] i_data,
  input  logic                           valid_in,
  output logic                           in_ready,
  output logic [DATA_WIDTH*CHANNELS-1:0] o_data,
  output logic                           valid_out,
  input  logic                           o_ready,
  output logic                           frame_done,
  output logic                           overflow,
  output logic [AW:0]                    wr_count
);
  localparam int DW = DATA_WIDTH * CHANNELS;
`ifdef FMAP_PINGPONG_EN
  localparam int   NB = 2;
  localparam logic PP = 1'b1;   // bank pointers toggle per frame
`else
  localparam int   NB = 1;
  localparam logic PP = 1'b0;   // bank pointers stay on bank 0
`endif
  localparam int MAW = $clog2(NB * DIM);

  // Per-bank state: FILL = free for writing, DRAIN = holds a frame whose last
  // beat has not yet been accepted downstream.
  typedef enum logic {BK_FILL, BK_DRAIN} bank_st_t;

  typedef struct packed {
    logic last;   // o_data is beat DIM-1 of its frame
    logic bank;   // bank that o_data came from
  } out_tag_t;

  logic [DW-1:0]  mem [NB*DIM];
  bank_st_t       st    [2];
  bank_st_t       st_nx [2];
  logic [1:0]     unissued;     // bank full and its reads not all issued yet
  logic           fill_bank, fill_nx, rd_bank;
  logic [AW-1:0]  wr_addr, rd_addr;
  logic [MAW-1:0] wr_ma, rd_ma;
  out_tag_t       o_tag;
  logic           wr_fire, wr_wrap, rd_fire, rd_wrap, acc_last;

  assign wr_fire  = valid_in & in_ready;
  assign wr_wrap  = wr_fire & (wr_addr == AW'(DIM - 1));
  // Issue a read whenever the output register is empty or being emptied,
  // which keeps one beat per cycle flowing while o_ready is held high.
  assign rd_fire  = unissued[rd_bank] & (~valid_out | o_ready);
  assign rd_wrap  = rd_fire & (rd_addr == AW'(DIM - 1));
  assign acc_last = valid_out & o_ready & o_tag.last;

  assign wr_ma = fill_bank ? MAW'(DIM) + MAW'(wr_addr) : MAW'(wr_addr);
  assign rd_ma = rd_bank   ? MAW'(DIM) + MAW'(rd_addr) : MAW'(rd_addr);

  assign wr_count = {1'b0, wr_addr};

  // A completed fill and a completed drain always touch different banks, since
  // a bank can only be written while it is in FILL.
  always_comb begin
    st_nx = st;
    if (acc_last) st_nx[o_tag.bank] = BK_FILL;
    if (wr_wrap)  st_nx[fill_bank]  = BK_DRAIN;
    fill_nx = wr_wrap ? (fill_bank ^ PP) : fill_bank;
  end

  always_ff @(posedge clk) begin
    if (rst && wr_fire) mem[wr_ma] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st[0]      <= BK_FILL;
      st[1]      <= BK_FILL;
      unissued   <= '0;
      fill_bank  <= 1'b0;
      rd_bank    <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      in_ready   <= 1'b0;
      valid_out  <= 1'b0;
      o_data     <= '0;
      o_tag      <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      st         <= st_nx;
      fill_bank  <= fill_nx;
      in_ready   <= (st_nx[fill_nx] == BK_FILL);
      frame_done <= acc_last;
      if (valid_in && !in_ready) overflow <= 1'b1;

      if (wr_fire) wr_addr <= wr_wrap ? '0 : wr_addr + 1'b1;

      if (rd_wrap) unissued[rd_bank]   <= 1'b0;
      if (wr_wrap) unissued[fill_bank] <= 1'b1;

      // The read pointer may move to the next queued bank while the previous
      // frame's last beat still sits in o_data, so frames replay back to back.
      if (rd_fire) begin
        o_data    <= mem[rd_ma];
        valid_out <= 1'b1;
        o_tag     <= '{last: (rd_addr == AW'(DIM - 1)), bank: rd_bank};
        rd_addr   <= rd_wrap ? '0 : rd_addr + 1'b1;
        if (rd_wrap) rd_bank <= rd_bank ^ PP;
      end else if (o_ready) begin
        valid_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fmap_frame_buffer.sv
// Scoreboard bench for fmap_frame_buffer: the stimulus side streams frames,
// a negedge monitor keeps a frame-level model (frames held, beats expected in
// replay order) and compares every handshake and status output against it.
module tb_fmap_frame_buffer;
  localparam int DATA_WIDTH = 32;
  localparam int CHANNELS   = 32;
  localparam int WIDTH      = 14;
  localparam int DIM        = WIDTH * WIDTH;
  localparam int AW         = $clog2(DIM);
  localparam int DW         = DATA_WIDTH * CHANNELS;
`ifdef FMAP_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          valid_in = 1'b0;
  logic          in_ready;
  logic [DW-1:0] o_data;
  logic          valid_out;
  logic          o_ready = 1'b0;
  logic          frame_done;
  logic          overflow;
  logic [AW:0]   wr_count;

  always #5 clk = ~clk;

  fmap_frame_buffer #(.DATA_WIDTH(DATA_WIDTH), .CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .valid_in(valid_in), .in_ready(in_ready),
    .o_data(o_data), .valid_out(valid_out), .o_ready(o_ready), .frame_done(frame_done),
    .overflow(overflow), .wr_count(wr_count)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [DW-1:0] cur_q[$];      // beats of the frame currently filling
  beat_t         exp_q[$];      // beats awaiting replay, in order
  int            held = 0;      // frames written and not yet fully replayed
  logic          exp_rdy = 1'b0, exp_ovf = 1'b0, exp_fd = 1'b0;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data = '0;
  int            cyc = 0, lat_due = -1;
  int            acc_cnt = 0, last_acc_cyc = -10, streak = 0, fd_cnt = 0;
  int            orm = 0;       // o_ready mode: 0 high, 1 pattern 1001, 2 random, 3 low

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w = '0;
    for (int i = 0; i < DW / 32; i++) w = {w[DW-33:0], 32'($urandom)};
    return w;
  endfunction

  // o_ready driver
  initial begin
    logic [3:0] pat = 4'b1001;
    int pc = 0;
    forever begin
      @(posedge clk); #1;
      case (orm)
        0: o_ready = 1'b1;
        1: begin o_ready = pat[pc % 4]; pc++; end
        2: o_ready = 1'($urandom_range(0, 1));
        default: o_ready = 1'b0;
      endcase
    end
  end

  // monitor + scoreboard
  always @(negedge clk) begin
    beat_t e;
    beat_t b;
    logic  acc;
    logic  nfd;
    cyc++;
    chk("in_ready",   DW'(in_ready),   DW'(exp_rdy));
    chk("overflow",   DW'(overflow),   DW'(exp_ovf));
    chk("frame_done", DW'(frame_done), DW'(exp_fd));
    chk("wr_count",   DW'(wr_count),   DW'(cur_q.size()));
    if (frame_done === 1'b1) fd_cnt++;
    if (hold_pend) begin
      chk("hold_valid", DW'(valid_out), DW'(1));
      chk("hold_data",  o_data,         hold_data);
    end
    if (lat_due == cyc) chk("first_beat_latency", DW'(valid_out), DW'(1));

    acc = (valid_out === 1'b1) && (o_ready === 1'b1);
    nfd = 1'b0;
    if (!rst) begin
      cur_q.delete();
      exp_q.delete();
      held = 0;
      exp_rdy = 1'b0;
      exp_ovf = 1'b0;
      hold_pend = 1'b0;
      lat_due = -1;
    end else begin
      hold_pend = (valid_out === 1'b1) && (o_ready !== 1'b1);
      hold_data = o_data;
      if (valid_out === 1'b1) chk("valid_has_expect", DW'(exp_q.size() != 0), DW'(1));
      if (acc && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("o_data", o_data, e.data);
        acc_cnt++;
        streak = (cyc == last_acc_cyc + 1) ? streak + 1 : 1;
        last_acc_cyc = cyc;
        if (e.last) begin
          held--;
          nfd = 1'b1;
        end
      end
      if (valid_in === 1'b1 && exp_rdy) begin
        cur_q.push_back(i_data);
        if (cur_q.size() == DIM) begin
          if (held == 0) lat_due = cyc + 2;
          for (int k = 0; k < DIM; k++) begin
            b.data = cur_q[k];
            b.last = (k == DIM - 1);
            exp_q.push_back(b);
          end
          cur_q.delete();
          held++;
        end
      end
      if (valid_in === 1'b1 && !exp_rdy) exp_ovf = 1'b1;
      exp_rdy = (held < NB);
    end
    exp_fd = nfd;
  end

  task automatic put_beat(input logic [DW-1:0] d);
    int n = 0;
    valid_in = 1'b1;
    i_data   = d;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 5000) begin
        tests++; fails++;
        $display("FAIL put_beat_timeout: in_ready low for %0d cycles, required 1", n);
        break;
      end
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit counting);
    for (int i = 0; i < n; i++) put_beat(counting ? DW'(i) : rand_word());
  endtask

  task automatic wait_drain();
    int n = 0;
    while (held != 0 || exp_q.size() != 0 || cur_q.size() != 0) begin
      @(posedge clk);
      n++;
      if (n > 6000) begin
        tests++; fails++;
        $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int fd0, a0;
    // 1: reset with valid_in held high
    valid_in = 1'b1;
    i_data   = rand_word();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  DW'(in_ready),  DW'(0));
    chk("rst_valid_out", DW'(valid_out), DW'(0));
    chk("rst_overflow",  DW'(overflow),  DW'(0));
    chk("rst_wr_count",  DW'(wr_count),  DW'(0));
    rst = 1'b1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    chk("rel_in_ready", DW'(in_ready), DW'(1));

    // 2: counting frame, free-flowing output
    orm = 0;
    fd0 = fd_cnt;
    send_frame(DIM, 1'b1);
    wait_drain();
    chk("t2_frame_done_once", DW'(fd_cnt - fd0), DW'(1));
    chk("t2_contiguous",      DW'(streak),       DW'(DIM));
    chk("t2_wr_count",        DW'(wr_count),     DW'(0));

    // 3: 1,0,0,1 backpressure
    orm = 1;
    send_frame(DIM, 1'b0);
    wait_drain();

    // 4: fill every bank with output stalled, then push 5 more beats
    orm = 3;
    repeat (NB) send_frame(DIM, 1'b0);
    valid_in = 1'b1;
    repeat (5) begin
      i_data = rand_word();
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    chk("t4_in_ready", DW'(in_ready), DW'(0));
    chk("t4_overflow", DW'(overflow), DW'(1));
    orm = 0;
    wait_drain();
    chk("t4_overflow_sticky", DW'(overflow), DW'(1));

    // 5: reset mid-frame, then a fresh frame
    send_frame(100, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_overflow_cleared", DW'(overflow), DW'(0));
    chk("t5_wr_count",         DW'(wr_count), DW'(0));
    send_frame(DIM, 1'b0);
    wait_drain();

    // random input gaps with random backpressure
    orm = 2;
    repeat (2) begin
      for (int i = 0; i < DIM; i++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        put_beat(rand_word());
      end
    end
    wait_drain();
    orm = 0;

`ifdef FMAP_PINGPONG_EN
    // 6: two frames back to back through both banks
    a0 = acc_cnt;
    send_frame(2 * DIM, 1'b0);
    wait_drain();
    chk("t6_beats",      DW'(acc_cnt - a0), DW'(2 * DIM));
    chk("t6_contiguous", DW'(streak),       DW'(2 * DIM));
    chk("t6_overflow",   DW'(overflow),     DW'(0));
`else
    a0 = acc_cnt;
`endif
    chk("final_expect_empty", DW'(exp_q.size()), DW'(0));
    chk("final_valid_out",    DW'(valid_out),    DW'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
